// File: rtl/mmio_timer_bank_pkg.sv
// Shared constants for the MMIO timer bank: register offsets, CTRL bit
// positions, channel stride, channel state encoding and a byte-mask helper.
package mmio_timer_bank_pkg;

  // Per-channel register offsets (within one channel window)
  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_RELOAD = 5'h04;
  localparam logic [4:0] OFF_COUNT  = 5'h08;
  localparam logic [4:0] OFF_CMP    = 5'h0C;
  localparam logic [4:0] OFF_CAP    = 5'h10;

  // Global register offsets and last decoded byte of the block
  localparam logic [8:0] OFF_STATUS = 9'h100;
  localparam logic [8:0] OFF_PRESC  = 9'h104;
  localparam logic [8:0] OFF_LAST   = 9'h107;

  // Channel i lives at i * CH_STRIDE
  localparam int unsigned CH_STRIDE = 32'h20;
  localparam int unsigned CH_SHIFT  = $clog2(CH_STRIDE);

  // CTRL bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_AR  = 1;
  localparam int CTRL_PWM = 2;
  localparam int CTRL_IRQ = 3;

  typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_e;

  // Expand 4 byte enables to a 32-bit write mask
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mmio_timer_bank_channel.sv
// One timer channel: down-counter with IDLE/RUN FSM, terminal flag,
// auto-reload and registered PWM compare. Optional input capture when
// TIMER_CAPTURE_EN is defined.
module timer_channel
  import mmio_timer_bank_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             wr_ctrl_i,
  input  logic             wr_reload_i,
  input  logic             wr_count_i,
  input  logic             wr_cmp_i,
  input  logic             clr_flag_i,
  input  logic [31:0]      wdata_i,
  input  logic [31:0]      wmask_i,
`ifdef TIMER_CAPTURE_EN
  input  logic             cap_in_i,
  input  logic             clr_cap_i,
  output logic [CNT_W-1:0] cap_o,
  output logic             cap_flag_o,
`endif
  output logic [3:0]       ctrl_o,
  output logic [CNT_W-1:0] reload_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] cmp_o,
  output logic             flag_o,
  output logic             irq_o,
  output logic             pwm_o
);

  ch_state_e        st_q;
  logic             ar_q, pwm_en_q, irq_en_q, flag_q, pwm_q;
  logic [CNT_W-1:0] cnt_q, reload_q, cmp_q;
  logic [CNT_W-1:0] wd, wm, cnt_d, reload_d, cmp_d;
  logic [3:0]       ctrl_cur, ctrl_d;
  logic             run, fire;
  logic             unused_w;

  assign run = (st_q == CH_RUN);

  // Current CTRL image; en reflects the FSM state
  always_comb begin
    ctrl_cur           = '0;
    ctrl_cur[CTRL_EN]  = run;
    ctrl_cur[CTRL_AR]  = ar_q;
    ctrl_cur[CTRL_PWM] = pwm_en_q;
    ctrl_cur[CTRL_IRQ] = irq_en_q;
  end

  // Byte-merged write values; bits above CNT_W are simply not stored
  assign wd       = wdata_i[CNT_W-1:0];
  assign wm       = wmask_i[CNT_W-1:0];
  assign cnt_d    = (cnt_q & ~wm) | (wd & wm);
  assign reload_d = (reload_q & ~wm) | (wd & wm);
  assign cmp_d    = (cmp_q & ~wm) | (wd & wm);
  assign ctrl_d   = (ctrl_cur & ~wmask_i[3:0]) | (wdata_i[3:0] & wmask_i[3:0]);
  assign unused_w = ^{wdata_i, wmask_i};

  // A COUNT write suppresses this cycle's hardware step entirely
  assign fire = run & tick_i & (cnt_q == '0) & ~wr_count_i;

  // Channel FSM: hardware step first, CPU writes afterwards so they win
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q     <= CH_IDLE;
      ar_q     <= 1'b0;
      pwm_en_q <= 1'b0;
      irq_en_q <= 1'b0;
      flag_q   <= 1'b0;
      pwm_q    <= 1'b0;
      cnt_q    <= '0;
      reload_q <= '0;
      cmp_q    <= '0;
    end else begin
      if (run && tick_i && !wr_count_i) begin
        if (cnt_q != '0)  cnt_q <= cnt_q - CNT_W'(1);
        else if (ar_q)    cnt_q <= reload_q;
        else              st_q  <= CH_IDLE;
      end
      // clear first, set last: a same-cycle set beats W1C
      if (wr_count_i || clr_flag_i) flag_q <= 1'b0;
      if (fire)                     flag_q <= 1'b1;
      if (wr_count_i)  cnt_q    <= cnt_d;
      if (wr_reload_i) reload_q <= reload_d;
      if (wr_cmp_i)    cmp_q    <= cmp_d;
      if (wr_ctrl_i) begin
        st_q     <= ctrl_d[CTRL_EN] ? CH_RUN : CH_IDLE;
        ar_q     <= ctrl_d[CTRL_AR];
        pwm_en_q <= ctrl_d[CTRL_PWM];
        irq_en_q <= ctrl_d[CTRL_IRQ];
      end
      pwm_q <= run & pwm_en_q & (cnt_q < cmp_q);
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]       cap_sync_q;
  logic [CNT_W-1:0] cap_q;
  logic             cap_flag_q, cap_edge;

  // [0],[1] synchroniser, [2] history for rising-edge detect
  assign cap_edge = cap_sync_q[1] & ~cap_sync_q[2];

  // Synchronise capture input and latch the live count on a rising edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_sync_q <= '0;
      cap_q      <= '0;
      cap_flag_q <= 1'b0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], cap_in_i};
      if (clr_cap_i) cap_flag_q <= 1'b0;
      if (cap_edge && run) begin
        cap_q      <= cnt_q;
        cap_flag_q <= 1'b1;
      end
    end
  end

  assign cap_o      = cap_q;
  assign cap_flag_o = cap_flag_q;
  assign irq_o      = irq_en_q & (flag_q | cap_flag_q);
`else
  assign irq_o      = irq_en_q & flag_q;
`endif

  assign ctrl_o   = ctrl_cur;
  assign reload_o = reload_q;
  assign count_o  = cnt_q;
  assign cmp_o    = cmp_q;
  assign flag_o   = flag_q;
  assign pwm_o    = pwm_q;

endmodule

// File: rtl/mmio_timer_bank.sv
// MMIO timer bank top: shared prescaler, address decode, read mux, STATUS
// W1C and N_CH timer_channel instances. Define TIMER_CAPTURE_EN to add the
// cap_in port, per-channel CAP registers and capture flags in STATUS[15:8].
module mmio_timer_bank
  import mmio_timer_bank_pkg::*;
#(
  parameter int          N_CH      = 2,
  parameter int          CNT_W     = 16,
  parameter int          PRESC_W   = 16,
  parameter logic [15:0] BASE_ADDR = 16'hFC80
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [15:0]     addr,
  input  logic [31:0]     wdata,
`ifdef TIMER_CAPTURE_EN
  input  logic [N_CH-1:0] cap_in,
`endif
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] timer_int,
  output logic [N_CH-1:0] pwm_out
);

  // ---- decode ----
  logic [16:0] off_full;
  logic [8:0]  off;
  logic [2:0]  ch_sel;
  logic [4:0]  reg_off;
  logic        in_range, ch_hit, wr_status, wr_presc;
  logic [31:0] wmask;

  assign off_full  = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_range  = !off_full[16] && (off_full[15:0] <= {7'b0, OFF_LAST});
  assign off       = off_full[8:0];
  assign ch_sel    = off[CH_SHIFT +: 3];
  assign reg_off   = off[CH_SHIFT-1:0];
  assign ch_hit    = in_range && !off[8] && ({1'b0, ch_sel} < 4'(N_CH));
  assign wmask     = byte_mask(be);
  assign wr_status = we && in_range && (off == OFF_STATUS);
  assign wr_presc  = we && in_range && (off == OFF_PRESC);

  // ---- prescaler ----
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic               tick;

  assign tick    = (pcnt_q == presc_q);
  assign presc_d = (presc_q & ~wmask[PRESC_W-1:0]) | (wdata[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
  assign pcnt_d  = (wr_presc || tick) ? '0 : pcnt_q + PRESC_W'(1);

  // Prescaler divide register and free-running phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      if (wr_presc) presc_q <= presc_d;
    end
  end

  // ---- channels ----
  logic [N_CH-1:0][3:0]       ch_ctrl;
  logic [N_CH-1:0][CNT_W-1:0] ch_reload, ch_count, ch_cmp, ch_cap;
  logic [N_CH-1:0]            flag, cap_flag;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic sel;
    assign sel = we && ch_hit && (ch_sel == 3'(g));

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_i       (clk),
      .rst_i       (rst),
      .tick_i      (tick),
      .wr_ctrl_i   (sel && (reg_off == OFF_CTRL)),
      .wr_reload_i (sel && (reg_off == OFF_RELOAD)),
      .wr_count_i  (sel && (reg_off == OFF_COUNT)),
      .wr_cmp_i    (sel && (reg_off == OFF_CMP)),
      .clr_flag_i  (wr_status && wdata[g] && wmask[g]),
      .wdata_i     (wdata),
      .wmask_i     (wmask),
`ifdef TIMER_CAPTURE_EN
      .cap_in_i    (cap_in[g]),
      .clr_cap_i   (wr_status && wdata[8+g] && wmask[8+g]),
      .cap_o       (ch_cap[g]),
      .cap_flag_o  (cap_flag[g]),
`endif
      .ctrl_o      (ch_ctrl[g]),
      .reload_o    (ch_reload[g]),
      .count_o     (ch_count[g]),
      .cmp_o       (ch_cmp[g]),
      .flag_o      (flag[g]),
      .irq_o       (timer_int[g]),
      .pwm_o       (pwm_out[g])
    );

`ifndef TIMER_CAPTURE_EN
    assign ch_cap[g]   = '0;
    assign cap_flag[g] = 1'b0;
`endif
  end

  // ---- read path ----
  logic [31:0] status_rd;

  // STATUS image: terminal flags low byte, capture flags second byte
  always_comb begin
    status_rd              = '0;
    status_rd[N_CH-1:0]    = flag;
    status_rd[8 +: N_CH]   = cap_flag;
  end

  // Combinational read mux; anything unmapped returns zero
  always_comb begin
    rdata = '0;
    if (ch_hit) begin
      for (int i = 0; i < N_CH; i++) begin
        if ({1'b0, ch_sel} == 4'(i)) begin
          case (reg_off)
            OFF_CTRL:   rdata = 32'(ch_ctrl[i]);
            OFF_RELOAD: rdata = 32'(ch_reload[i]);
            OFF_COUNT:  rdata = 32'(ch_count[i]);
            OFF_CMP:    rdata = 32'(ch_cmp[i]);
            OFF_CAP:    rdata = 32'(ch_cap[i]);
            default:    rdata = '0;
          endcase
        end
      end
    end else if (in_range && (off == OFF_STATUS)) begin
      rdata = status_rd;
    end else if (in_range && (off == OFF_PRESC)) begin
      rdata = 32'(presc_q);
    end
  end

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed bench for mmio_timer_bank (default build, N_CH=2, CNT_W=16).
module tb_mmio_timer_bank;

  localparam int          N_CH = 2;
  localparam logic [15:0] BASE = 16'hFC80;
  localparam logic [15:0] A_STATUS = BASE + 16'h100;
  localparam logic [15:0] A_PRESC  = BASE + 16'h104;

  logic            clk = 1'b0;
  logic            rst, we;
  logic [3:0]      be;
  logic [15:0]     addr;
  logic [31:0]     wdata, rdata;
  logic [N_CH-1:0] timer_int, pwm_out;
`ifdef TIMER_CAPTURE_EN
  logic [N_CH-1:0] cap_in = '0;
`endif

  int n_vec = 0;
  int n_err = 0;

  mmio_timer_bank #(.N_CH(N_CH), .CNT_W(16), .PRESC_W(16), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .be        (be),
    .addr      (addr),
    .wdata     (wdata),
`ifdef TIMER_CAPTURE_EN
    .cap_in    (cap_in),
`endif
    .rdata     (rdata),
    .timer_int (timer_int),
    .pwm_out   (pwm_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ra(input int ch, input logic [7:0] o);
    return BASE + 16'(ch * 32) + {8'h00, o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus write: drive now (just after a negedge), commit on the next posedge
  task automatic wrb(input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; addr = a; wdata = d; be = b;
    @(negedge clk);
    we = 1'b0; be = 4'h0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    wrb(a, d, 4'hF);
  endtask

  task automatic chkr(input string tag, input logic [15:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_ones(input int ch, input int n, output int ones);
    ones = 0;
    repeat (n) begin
      @(negedge clk);
      ones += int'(pwm_out[ch]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ones;
    rst = 1'b1; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    chkr("rst_ctrl0", ra(0, 8'h00), 0);
    chkr("rst_count1", ra(1, 8'h08), 0);
    chkr("rst_status", A_STATUS, 0);
    chk("rst_int_pwm", {timer_int, pwm_out}, 0);

    // one-shot: COUNT=5 -> flag 6 cycles after enable, en auto-clears
    wr(ra(0, 8'h08), 5);
    wr(ra(0, 8'h00), 1);
    cyc(5);
    chkr("os_flag_early", A_STATUS, 0);
    cyc(1);
    chkr("os_flag", A_STATUS, 1);
    chkr("os_ctrl", ra(0, 8'h00), 0);
    chkr("os_count", ra(0, 8'h08), 0);
    chk("os_int", timer_int, 0);
    cyc(2);
    chkr("os_count_hold", ra(0, 8'h08), 0);
    wr(A_STATUS, 1);
    chkr("os_w1c", A_STATUS, 0);

    // auto-reload with irq on ch1, period 4
    wr(ra(1, 8'h04), 3);
    wr(ra(1, 8'h08), 3);
    wr(ra(1, 8'h00), 32'hB);
    cyc(3);
    chk("ar_int_early", timer_int, 0);
    cyc(1);
    chk("ar_int", timer_int, 2'b10);
    for (int k = 0; k < 2; k++) begin
      wr(A_STATUS, 2);
      chk("ar_int_cleared", timer_int, 0);
      cyc(3);
      chk("ar_int_again", timer_int, 2'b10);
    end
    wr(ra(1, 8'h00), 0);
    wr(A_STATUS, 3);
    chkr("ar_status_clr", A_STATUS, 0);

    // prescaler 4: ticks every 5 cycles, flag 15 cycles after PRESC write
    wr(A_PRESC, 4);
    wr(ra(0, 8'h08), 2);
    wr(ra(0, 8'h00), 1);
    chkr("ps_presc", A_PRESC, 4);
    cyc(12);
    chkr("ps_flag_early", A_STATUS, 0);
    cyc(1);
    chkr("ps_flag", A_STATUS, 1);
    wr(A_STATUS, 1);
    // rewriting PRESC mid-count restarts the tick phase
    wr(A_PRESC, 4);
    wr(ra(0, 8'h08), 2);
    wr(ra(0, 8'h00), 1);
    cyc(4);
    chkr("ps_cnt_after_tick", ra(0, 8'h08), 1);
    wr(A_PRESC, 4);
    cyc(9);
    chkr("ps_restart_early", A_STATUS, 0);
    cyc(1);
    chkr("ps_restart_flag", A_STATUS, 1);
    wr(A_PRESC, 0);
    wr(A_STATUS, 1);

    // PWM: RELOAD=9, CMP=3 -> 3 high of every 10
    wr(ra(0, 8'h04), 9);
    wr(ra(0, 8'h0C), 3);
    wr(ra(0, 8'h08), 9);
    wr(ra(0, 8'h00), 7);
    cyc(2);
    pwm_ones(0, 10, ones);
    chk("pwm_duty10", ones, 3);
    pwm_ones(0, 20, ones);
    chk("pwm_duty20", ones, 6);
    wr(ra(0, 8'h0C), 0);
    cyc(2);
    pwm_ones(0, 20, ones);
    chk("pwm_cmp0", ones, 0);
    wr(ra(0, 8'h0C), 15);
    cyc(2);
    pwm_ones(0, 10, ones);
    chk("pwm_cmp_gt", ones, 10);
    wr(ra(0, 8'h00), 0);
    cyc(1);
    chk("pwm_off", pwm_out, 0);
    wr(A_STATUS, 1);

    // COUNT write beats decrement and clears flag; flag set beats W1C
    wr(ra(0, 8'h04), 1);
    wr(ra(0, 8'h08), 0);
    wr(ra(0, 8'h00), 3);
    cyc(1);
    chkr("pri_flag_set", A_STATUS, 1);
    chkr("pri_reloaded", ra(0, 8'h08), 1);
    wr(ra(0, 8'h08), 7);
    chkr("pri_count7", ra(0, 8'h08), 7);
    chkr("pri_flag_clr", A_STATUS, 0);
    cyc(7);
    chkr("pri_count0", ra(0, 8'h08), 0);
    wr(A_STATUS, 1);
    chkr("pri_set_wins", A_STATUS, 1);
    chkr("pri_reload2", ra(0, 8'h08), 1);
    wr(ra(0, 8'h00), 0);
    wr(A_STATUS, 1);
    chkr("pri_cleanup", A_STATUS, 0);

    // byte enables, width truncation, unmapped offsets
    wr(ra(0, 8'h0C), 32'hFFFF);
    wrb(ra(0, 8'h0C), 32'h1234ABCD, 4'b0001);
    chkr("be_cmp", ra(0, 8'h0C), 32'hFFCD);
    wr(ra(0, 8'h04), 32'hFFFFFFFF);
    chkr("trunc_reload", ra(0, 8'h04), 32'h0000FFFF);
    wrb(ra(0, 8'h04), 32'h00005500, 4'b0010);
    chkr("be_reload", ra(0, 8'h04), 32'h000055FF);
    chkr("unm_18", ra(0, 8'h18), 0);
    chkr("unm_cap", ra(0, 8'h10), 0);
    chkr("unm_ch2", ra(2, 8'h00), 0);
    chkr("unm_108", BASE + 16'h108, 0);

    // reset mid-run
    wr(ra(1, 8'h04), 2);
    wr(ra(1, 8'h08), 2);
    wr(ra(1, 8'h0C), 5);
    wr(ra(1, 8'h00), 32'hF);
    cyc(4);
    chk("mr_int_before", timer_int, 2'b10);
    chk("mr_pwm_before", pwm_out, 2'b10);
    wr(A_PRESC, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_int", timer_int, 0);
    chk("mr_pwm", pwm_out, 0);
    chkr("mr_ctrl1", ra(1, 8'h00), 0);
    chkr("mr_reload1", ra(1, 8'h04), 0);
    chkr("mr_count1", ra(1, 8'h08), 0);
    chkr("mr_cmp1", ra(1, 8'h0C), 0);
    chkr("mr_reload0", ra(0, 8'h04), 0);
    chkr("mr_cmp0", ra(0, 8'h0C), 0);
    chkr("mr_status", A_STATUS, 0);
    chkr("mr_presc", A_PRESC, 0);
    chkr("mr_unm_18", ra(0, 8'h18), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_timer_bank.md
Name: mmio_timer_bank

Overview:
Parametrised multi-channel timer/counter peripheral on the CPU MMIO bus. It supersedes the fixed two-timer logic with N_CH identical channels. Each channel has one-shot or auto-reload down-counting, a shared prescaler, a per-channel PWM compare output, and maskable interrupts. Flags clear by write-1-to-clear. It sits beside the other MMIO peripherals; the bus decoder selects it when addr falls in [BASE_ADDR, BASE_ADDR+0x107].

Parameters:
N_CH, 2, number of timer channels (1..8)
CNT_W, 16, counter/reload/compare width (1..32)
PRESC_W, 16, prescaler register width
BASE_ADDR, 16'hFC80, byte address of channel 0 CTRL

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
we  in  1  write strobe
be  in  4  byte enables for the write
addr  in  16  low 16 bits of the byte address
wdata  in  32  write data
rdata  out  32  combinational read data; 0 for unmapped offsets
timer_int  out  N_CH  level interrupt per channel = flag[i] & irq_en[i]
pwm_out  out  N_CH  registered PWM output per channel

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Register map (offset from BASE_ADDR, channel i at i*0x20):
  - +0x00 CTRL: bit0 en, bit1 auto_reload, bit2 pwm_en, bit3 irq_en.
  - +0x04 RELOAD.
  - +0x08 COUNT: read = live count; write = load count.
  - +0x0C CMP.
- Global registers:
  - 0x100 STATUS: read = flag[N_CH-1:0]; write 1 to clear a bit.
  - 0x104 PRESC: divide value.
- Writes honour be[3:0] per byte. Bits above CNT_W/PRESC_W are dropped on write and read as 0.
- Reset: all CTRL=0, RELOAD=0, COUNT=0, CMP=0, flags=0, PRESC=0, prescaler counter=0, pwm_out=0. timer_int=0 follows.
- Prescaler:
  - presc_cnt increments every cycle.
  - When presc_cnt==PRESC: tick=1 and presc_cnt<=0.
  - PRESC=0 gives a tick every cycle.
  - A write to PRESC also zeroes presc_cnt.
- Channel FSM, per channel, states IDLE (en=0) and RUN (en=1):
  - RUN, on tick, count>0: count<=count-1.
  - RUN, on tick, count==0: flag<=1. If auto_reload, count<=RELOAD and stay in RUN. Else en<=0, go to IDLE, count stays 0.
  - IDLE: count holds; no flag activity.
- Timing: the flag is set in the cycle after the tick that observes count==0. An initial load of L with PRESC=0 raises the flag L+1 cycles after en rises.
- Priority: CPU write to COUNT or CTRL in the same cycle beats the hardware update to that register. Writing COUNT clears that channel's flag.
- Flag set and STATUS W1C in the same cycle: the set wins.
- PWM:
  - pwm_out[i] <= en & pwm_en & (count < CMP), registered, 1-cycle latency.
  - CMP=0 gives constant 0. CMP>RELOAD gives constant 1 while running.
- Wrap: no underflow past 0. Auto-reload with RELOAD=0 sets the flag on every tick.
- Reads have no side effects; flags clear only by write.

Optional Feature:
Macro TIMER_CAPTURE_EN.
- When defined:
  - Adds input port cap_in[N_CH-1:0].
  - Each input passes a 2-flop synchroniser and rising-edge detect.
  - On an edge while en=1, count is latched into CAP at +0x10 (read-only).
  - Sets cap_flag[i], which reads at STATUS bits [15:8] and is W1C.
  - timer_int[i] also asserts on cap_flag[i] & irq_en[i].
- When undefined: no port, +0x10 reads 0, STATUS[15:8] reads 0.

Decomposition:
- Shared package holds:
  - register offset constants (CTRL/RELOAD/COUNT/CMP/CAP/STATUS/PRESC);
  - CTRL bit-index constants;
  - channel stride 0x20.
- One sub-module, timer_channel: holds the counter, FSM, flag and PWM compare. It takes tick, the decoded write strobes and wdata. It is instantiated N_CH times with generate.
- The top keeps the prescaler, address decode, read mux and STATUS.

Test Plan:
- PRESC=0, ch0 COUNT=5, CTRL=0x1 → flag0 rises 6 cycles after enable; CTRL.en reads 0; count stays 0; timer_int0 stays 0 (irq_en=0).
- ch1 RELOAD=3, COUNT=3, CTRL=0xB → timer_int1 high after 4 cycles. W1C STATUS=0x2 clears it; it re-asserts 4 cycles later; this repeats.
- PRESC=4, COUNT=2, en → flag after 15 cycles (3 ticks × 5). Writing PRESC mid-count restarts tick spacing.
- ch0 RELOAD=9, CMP=3, CTRL=0x7 → pwm_out0 duty 3/10 high, period 10 cycles. CMP=0 → constant low.
- Write COUNT=7 in the same cycle the hardware decrements → COUNT reads 7 and the flag is cleared. W1C in the same cycle as the flag set → flag remains 1.
- rst asserted mid-run → next cycle all registers, pwm_out and timer_int are 0. Reading offset 0x18 returns 0.
